pipe_rca_adder: RTL and testbench

Parametrised, pipelined ripple-carry adder/subtractor that splits a WIDTH-bit operation into CHUNK-bit ripple slices, one slice per pipeline stage, with valid/ready flow control on both sides. It is the next generation of the team's combinational full-adder/RCA64 blocks. It gives a registered, back-pressurable arithmetic unit of arbitrary width for the datapath, sustaining one result per cycle.

---
 rtl/adder_pkg.sv | 25 ++
 rtl/rca_chunk.sv | 33 +++
 rtl/pipe_rca_adder.sv | 136 +++++++++++++
 tb/tb_pipe_rca_adder.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined ripple-carry adder family: default
// geometry, the stage-register layout and the geometry legality test.
package adder_pkg;

  localparam int ADDER_WIDTH  = 64;
  localparam int ADDER_CHUNK  = 16;
  localparam int ADDER_STAGES = ADDER_WIDTH / ADDER_CHUNK;

  // A geometry is usable when each stage resolves a whole, non-empty chunk.
  function automatic bit geometry_ok(input int width, input int chunk);
    return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
  endfunction

  localparam bit ADDER_GEOM_OK = geometry_ok(ADDER_WIDTH, ADDER_CHUNK);

  // Contents of one stage register at the default geometry.
  typedef struct packed {
    logic                   vld;
    logic [ADDER_WIDTH-1:0] opa;
    logic [ADDER_WIDTH-1:0] opb;
    logic [ADDER_WIDTH-1:0] psum;
    logic                   carry;
  } adder_stage_t;

endpackage

// File: rtl/rca_chunk.sv
// Combinational CHUNK-bit ripple of full adders. Besides the carry out of the
// top bit it exposes the carry into the top bit, so the final stage can form
// two's-complement overflow.
module rca_chunk
  import adder_pkg::*;
#(
  parameter int CHUNK = ADDER_CHUNK
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  logic [CHUNK:0] c;

  // Full-adder ripple from bit 0 upwards
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout     = c[CHUNK];
  assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/pipe_rca_adder.sv
// Pipelined ripple-carry adder/subtractor. Stage k resolves chunk k and passes
// the still-unresolved operand bits, the completed low sum bits and the chunk
// carry to stage k+1. Valid/ready handshakes on both sides; the stall chain
// is combinational so a full pipe keeps accepting while the consumer drains.
module pipe_rca_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH,
  parameter int CHUNK = ADDER_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = WIDTH / CHUNK;

  if (!geometry_ok(WIDTH, CHUNK)) begin : g_geom_check
    $error("pipe_rca_adder: WIDTH must be a non-zero multiple of CHUNK");
  end

  logic [STAGES-1:0] vld_p;
  logic [STAGES-1:0] adv_p;
  logic [STAGES-1:0] load_p;
  logic [STAGES:0]   room_p;
  logic [WIDTH-1:0]  sum_q;
  logic              cout_q;
  logic              cmsb_q;

  // Stall chain: a stage has room when it is empty or its word moves on
  always_comb begin
    room_p         = '0;
    adv_p          = '0;
    load_p         = '0;
    room_p[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      adv_p[k]  = vld_p[k] & room_p[k+1];
      room_p[k] = ~vld_p[k] | adv_p[k];
    end
    load_p[0] = in_valid & room_p[0];
    for (int k = 1; k < STAGES; k++) begin
      load_p[k] = adv_p[k-1];
    end
  end

  // Stage valid bits: set on load, cleared when the word leaves unreplaced
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p <= '0;
    end else begin
      vld_p <= load_p | (vld_p & ~adv_p);
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int IW = WIDTH - k * CHUNK;        // unresolved bits on entry
    localparam int SW = (k + 1) * CHUNK;          // sum bits done on exit
    localparam int RW = WIDTH - (k + 1) * CHUNK;  // unresolved bits on exit

    logic [IW-1:0]    ra;
    logic [IW-1:0]    rb;
    logic             cc;
    logic [CHUNK-1:0] cs;
    logic             co;
    logic             cm;
    logic [SW-1:0]    ps_d;

    if (k == 0) begin : g_in
      assign ra   = a;
      assign rb   = b ^ {WIDTH{sub}};
      assign cc   = sub | cin;
      assign ps_d = cs;
    end else begin : g_in
      assign ra   = g_st[k-1].g_mid.opa_q;
      assign rb   = g_st[k-1].g_mid.opb_q;
      assign cc   = g_st[k-1].g_mid.c_q;
      assign ps_d = {cs, g_st[k-1].g_mid.ps_q};
    end

    rca_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a        (ra[CHUNK-1:0]),
      .b        (rb[CHUNK-1:0]),
      .cin      (cc),
      .s        (cs),
      .cout     (co),
      .c_msb_in (cm)
    );

    if (k < STAGES - 1) begin : g_mid
      logic [RW-1:0] opa_q;
      logic [RW-1:0] opb_q;
      logic [SW-1:0] ps_q;
      logic          c_q;

      // ---- stage boundary k -> k+1: remaining operands, partial sum, carry
      always_ff @(posedge clk) begin
        if (load_p[k]) begin
          opa_q <= ra[IW-1:CHUNK];
          opb_q <= rb[IW-1:CHUNK];
          ps_q  <= ps_d;
          c_q   <= co;
        end
      end
    end else begin : g_last
      // ---- output boundary: full sum, carry out and carry into the MSB
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sum_q  <= '0;
          cout_q <= 1'b0;
          cmsb_q <= 1'b0;
        end else if (load_p[k]) begin
          sum_q  <= ps_d;
          cout_q <= co;
          cmsb_q <= cm;
        end
      end
    end
  end

  assign in_ready  = room_p[0];
  assign out_valid = vld_p[STAGES-1];
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = cmsb_q ^ cout_q;

endmodule

// File: tb/tb_pipe_rca_adder.sv
// Directed and streamed checks of pipe_rca_adder at WIDTH=64, CHUNK=16.
module tb_pipe_rca_adder;

  localparam int WIDTH  = 64;
  localparam int CHUNK  = 16;
  localparam int STAGES = WIDTH / CHUNK;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_rca_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  task automatic chkw(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: {ovf, cout, sum} from a plain WIDTH+1 bit addition
  function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                             input logic ci, input logic s);
    logic [WIDTH-1:0] yy;
    logic [WIDTH:0]   r;
    logic             c0;
    logic             v;
    yy = s ? ~y : y;
    c0 = s ? 1'b1 : ci;
    r  = {1'b0, x} + {1'b0, yy} + {{WIDTH{1'b0}}, c0};
    v  = (x[WIDTH-1] == yy[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
    return {v, r};
  endfunction

  // One word through an otherwise idle pipe, checking latency and result
  task automatic single(input string tag, input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                        input logic xc, input logic xs, input logic [WIDTH-1:0] esum,
                        input logic ecout, input logic eovf);
    int lat;
    a = xa; b = xb; cin = xc; sub = xs;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    chk1({tag, "/in_ready"}, in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chki({tag, "/latency"}, lat, STAGES);
    chkw({tag, "/sum"}, sum, esum);
    chk1({tag, "/cout"}, cout, ecout);
    chk1({tag, "/ovf"}, ovf, eovf);
    @(posedge clk); #1;
    chk1({tag, "/drained"}, out_valid, 1'b0);
  endtask

  // Random stream of n words, optionally with random consumer backpressure
  task automatic stream(input string tag, input int n, input bit rnd_ready);
    logic [WIDTH+1:0] q[$];
    logic [WIDTH+1:0] exp;
    logic [WIDTH+1:0] held;
    int sent, got, inflight, cyc;
    bit stall, acc, emt;
    sent = 0; got = 0; inflight = 0; cyc = 0;
    stall = 1'b0;
    held  = '0;
    a = {$urandom, $urandom}; b = {$urandom, $urandom};
    cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
    while (got < n && cyc < 10 * n + 50) begin
      in_valid  = (sent < n);
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      acc = in_valid && in_ready;
      emt = out_valid && out_ready;
      chk1({tag, "/in_ready"}, in_ready, out_ready || (inflight < STAGES));
      if (inflight == 0) chk1({tag, "/idle_valid"}, out_valid, 1'b0);
      if (stall) begin
        chk1({tag, "/hold_valid"}, out_valid, 1'b1);
        chkw({tag, "/hold_sum"}, sum, held[WIDTH-1:0]);
        chk1({tag, "/hold_cout"}, cout, held[WIDTH]);
        chk1({tag, "/hold_ovf"}, ovf, held[WIDTH+1]);
      end
      if (emt) begin
        if (q.size() == 0) begin
          chk1({tag, "/spurious"}, out_valid, 1'b0);
        end else begin
          exp = q.pop_front();
          chkw({tag, "/sum"}, sum, exp[WIDTH-1:0]);
          chk1({tag, "/cout"}, cout, exp[WIDTH]);
          chk1({tag, "/ovf"}, ovf, exp[WIDTH+1]);
        end
      end
      stall = out_valid && !out_ready;
      held  = {ovf, cout, sum};
      if (acc) q.push_back(model(a, b, cin, sub));
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        sent++;
        inflight++;
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
      end
      if (emt) begin
        got++;
        inflight--;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chki({tag, "/count"}, got, n);
    if (!rnd_ready) chki({tag, "/cycles"}, cyc, n + STAGES);
    #1;
    chk1({tag, "/empty"}, out_valid, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    #3;
    chk1("reset/out_valid", out_valid, 1'b0);
    chk1("reset/in_ready", in_ready, 1'b1);
    chkw("reset/sum", sum, '0);
    chk1("reset/cout", cout, 1'b0);
    chk1("reset/ovf", ovf, 1'b0);
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;

    single("add_ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0);
    single("sub_borrow", 64'd5, 64'd7, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    single("sub_noborrow", 64'd7, 64'd5, 1'b0, 1'b1, 64'd2, 1'b1, 1'b0);
    single("pos_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    single("neg_ovf", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'd0, 1'b1, 1'b1);
    single("add_cin", 64'h0000_0000_0000_FFFF, 64'd0, 1'b1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0);

    stream("stream", 100, 1'b0);
    stream("bp", 200, 1'b1);

    // Three words in flight, then an asynchronous reset mid-cycle
    in_valid = 1'b1; out_ready = 1'b1; sub = 1'b0; cin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a = 64'(100 + i); b = 64'(1000 + i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk1("midreset/out_valid", out_valid, 1'b0);
    chk1("midreset/in_ready", in_ready, 1'b1);
    chkw("midreset/sum", sum, '0);
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    single("after_reset", 64'd2, 64'd3, 1'b0, 1'b0, 64'd5, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
